// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler for the DDS frequency control word.
// Steps freq_word from start to stop with a programmable dwell per point.
module dds_sweep_ctrl #(
    parameter int FW_W    = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [FW_W-1:0]    f_start,
    input  logic [FW_W-1:0]    f_stop,
    input  logic [FW_W-1:0]    f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [1:0]         mode,
    output logic [FW_W-1:0]    freq_word,
    output logic               busy,
    output logic               step_strobe,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

    state_t             state, state_n;
    logic [FW_W-1:0]    sh_start, sh_stop, sh_step;
    logic [DWELL_W-1:0] sh_dwell;
    logic [1:0]         sh_mode;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [FW_W-1:0]    fw_n;
    logic               dir, dir_n;   // 0 = up, 1 = down
    logic               busy_n, strobe_n, done_n;

    logic               load;
    logic [FW_W-1:0]    step_in;
    logic [DWELL_W-1:0] dwell_in;
    logic [FW_W:0]      up_sum, lo_sum;
    logic [FW_W-1:0]    up_val, dn_val;
    logic               single, degenerate;

    assign load     = (state == IDLE) && start && !stop;
    assign step_in  = (f_step == '0) ? FW_W'(1) : f_step;
    assign dwell_in = (dwell == '0) ? DWELL_W'(1) : dwell;

    // Clamped neighbours of the current word, evaluated one bit wider so nothing wraps.
    assign up_sum = {1'b0, freq_word} + {1'b0, sh_step};
    assign lo_sum = {1'b0, sh_start} + {1'b0, sh_step};
    assign up_val = (up_sum > {1'b0, sh_stop}) ? sh_stop : up_sum[FW_W-1:0];
    assign dn_val = ({1'b0, freq_word} >= lo_sum) ? (freq_word - sh_step) : sh_start;

    assign single     = (sh_mode == 2'b00) || (sh_mode == 2'b11);
    assign degenerate = (sh_start >= sh_stop);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sh_start <= '0;
            sh_stop  <= '0;
            sh_step  <= FW_W'(1);
            sh_dwell <= DWELL_W'(1);
            sh_mode  <= '0;
        end else if (load) begin
            sh_start <= f_start;
            sh_stop  <= f_stop;
            sh_step  <= step_in;
            sh_dwell <= dwell_in;
            sh_mode  <= mode;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= IDLE;
            freq_word   <= '0;
            busy        <= 1'b0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
            dir         <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_n;
            freq_word   <= fw_n;
            busy        <= busy_n;
            step_strobe <= strobe_n;
            done        <= done_n;
            dir         <= dir_n;
            cnt         <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        fw_n     = freq_word;
        busy_n   = busy;
        strobe_n = 1'b0;
        done_n   = 1'b0;
        dir_n    = dir;
        cnt_n    = cnt;
        case (state)
            IDLE: begin
                if (load) begin
                    state_n = DWELL;
                    fw_n    = f_start;
                    busy_n  = 1'b1;
                    dir_n   = 1'b0;
                    cnt_n   = dwell_in;
                end
            end
            DWELL: begin
                if (stop) begin
                    state_n = IDLE;
                    fw_n    = '0;
                    busy_n  = 1'b0;
                    dir_n   = 1'b0;
                    cnt_n   = '0;
                end else if (cnt > DWELL_W'(1)) begin
                    cnt_n = cnt - DWELL_W'(1);
                end else begin
                    cnt_n = sh_dwell;
                    if (!dir) begin
                        if (freq_word < sh_stop) begin
                            fw_n     = up_val;
                            strobe_n = 1'b1;
                        end else if (single) begin
                            state_n = DONE;
                            fw_n    = '0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            cnt_n   = '0;
                        end else if (degenerate) begin
                            fw_n = freq_word;
                        end else if (sh_mode == 2'b01) begin
                            fw_n     = sh_start;
                            strobe_n = 1'b1;
                        end else begin
                            dir_n    = 1'b1;
                            fw_n     = dn_val;
                            strobe_n = 1'b1;
                        end
                    end else begin
                        // At the start boundary, up_val from freq_word equals min(start+S, stop).
                        if (freq_word > sh_start) begin
                            fw_n = dn_val;
                        end else begin
                            dir_n = 1'b0;
                            fw_n  = up_val;
                        end
                        strobe_n = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                fw_n    = '0;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                fw_n    = '0;
                busy_n  = 1'b0;
                dir_n   = 1'b0;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a point-list reference model feeds expected
// per-cycle outputs into a queue that an independent monitor drains.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  f_start = '0;
    logic [7:0]  f_stop = '0;
    logic [7:0]  f_step = '0;
    logic [15:0] dwell = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  freq_word;
    logic        busy, step_strobe, done;

    dds_sweep_ctrl #(.FW_W(8), .DWELL_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
        .mode(mode), .freq_word(freq_word), .busy(busy),
        .step_strobe(step_strobe), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] fw;
        logic       busy;
        logic       strb;
        logic       done;
    } exp_t;

    exp_t sb[$];
    exp_t trace[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int fw, input bit b, input bit s, input bit d);
        exp_t e;
        e.fw = 8'(fw);
        e.busy = b;
        e.strb = s;
        e.done = d;
        return e;
    endfunction

    // Expected cycle-by-cycle outputs starting with the cycle after the start edge.
    task automatic build_trace(input int fs, input int fe, input int st, input int dw,
                               input int md, input int stop_at);
        int S, D, v;
        int up[$];
        int dn[$];
        int pts[$];
        bit cyc;
        S = (st == 0) ? 1 : st;
        D = (dw == 0) ? 1 : dw;
        cyc = (md == 1) || (md == 2);
        trace.delete();
        v = fs;
        up.push_back(v);
        while (v < fe) begin
            v = (v + S > fe) ? fe : v + S;
            up.push_back(v);
        end
        v = fe;
        if (fs < fe) begin
            while (v > fs) begin
                v = (v - S < fs) ? fs : v - S;
                dn.push_back(v);
            end
        end
        if (cyc && fs >= fe) begin
            for (int k = 0; k < stop_at; k++) trace.push_back(mk(fs, 1, 0, 0));
        end else begin
            foreach (up[i]) pts.push_back(up[i]);
            if (cyc) begin
                while (pts.size() <= stop_at) begin
                    if (md == 1) begin
                        foreach (up[i]) pts.push_back(up[i]);
                    end else begin
                        foreach (dn[i]) pts.push_back(dn[i]);
                        for (int i = 1; i < up.size(); i++) pts.push_back(up[i]);
                    end
                end
            end
            foreach (pts[i])
                for (int c = 0; c < D; c++)
                    trace.push_back(mk(pts[i], 1, (i > 0) && (c == 0), 0));
        end
        if (stop_at > 0 && trace.size() >= stop_at) begin
            while (trace.size() > stop_at) void'(trace.pop_back());
            trace.push_back(mk(0, 0, 0, 0));
            trace.push_back(mk(0, 0, 0, 0));
        end else begin
            trace.push_back(mk(0, 0, 0, 1));
            trace.push_back(mk(0, 0, 0, 0));
        end
    endtask

    task automatic run_txn(input int fs, input int fe, input int st, input int dw,
                           input int md, input int stop_at);
        int t;
        build_trace(fs, fe, st, dw, md, stop_at);
        @(negedge clk);
        f_start = 8'(fs);
        f_stop  = 8'(fe);
        f_step  = 8'(st);
        dwell   = 16'(dw);
        mode    = 2'(md);
        start   = 1'b1;
        stop    = 1'b0;
        foreach (trace[i]) sb.push_back(trace[i]);
        for (int k = 1; k < trace.size(); k++) begin
            @(negedge clk);
            start   = (trace[k-1].busy || trace[k-1].done) && ($urandom_range(0, 7) == 0);
            stop    = (k == stop_at);
            f_start = 8'($urandom);
            f_stop  = 8'($urandom);
            f_step  = 8'($urandom);
            dwell   = 16'($urandom_range(0, 9));
            mode    = 2'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        t = 0;
        while (sb.size() > 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_drain", sb.size(), 0);
        sb.delete();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("freq_word", freq_word, e.fw);
                chk("busy", busy, e.busy);
                chk("step_strobe", step_strobe, e.strb);
                chk("done", done, e.done);
            end
        end
    end

    initial begin : watchdog
        #5ms;
        n_bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : main
        int fs, fe, st, dw, md, sa;
        #1 rst_n = 1'b1;
        #2;
        chk("rst_freq_word", freq_word, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", step_strobe, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        run_txn(10, 40, 10, 3, 0, 0);
        run_txn(5, 20, 7, 1, 1, 10);
        run_txn(0, 8, 4, 2, 2, 9);
        run_txn(250, 255, 4, 1, 0, 0);
        run_txn(3, 9, 0, 0, 0, 0);
        run_txn(50, 50, 5, 0, 0, 0);
        run_txn(60, 30, 5, 2, 1, 8);
        run_txn(60, 30, 5, 1, 2, 6);
        run_txn(0, 20, 7, 1, 2, 25);
        run_txn(100, 255, 200, 2, 2, 20);
        run_txn(10, 40, 10, 3, 0, 7);

        // start and stop together while idle: nothing happens
        @(negedge clk);
        f_start = 8'd33; f_stop = 8'd99; f_step = 8'd1; dwell = 16'd1; mode = 2'b00;
        start = 1'b1; stop = 1'b1;
        sb.push_back(mk(0, 0, 0, 0));
        sb.push_back(mk(0, 0, 0, 0));
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);

        for (int n = 0; n < 30; n++) begin
            fs = $urandom_range(0, 255);
            fe = ($urandom_range(0, 4) == 0) ? $urandom_range(0, fs) : $urandom_range(0, 255);
            st = $urandom_range(0, 80);
            dw = $urandom_range(0, 4);
            md = $urandom_range(0, 3);
            if (md == 1 || md == 2) sa = $urandom_range(5, 60);
            else sa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
            run_txn(fs, fe, st, dw, md, sa);
        end

        // asynchronous reset between clock edges mid-sweep
        @(negedge clk);
        f_start = 8'd10; f_stop = 8'd40; f_step = 8'd10; dwell = 16'd3; mode = 2'b10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_freq", freq_word, 20);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("async_rst_freq", freq_word, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_strobe", step_strobe, 0);
        chk("async_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b0;
        run_txn(10, 40, 10, 3, 2, 15);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Frequency-sweep scheduler that drives the 8-bit frequency control word of the DDS sine generator (10 MHz system clock).
- Steps the word from a start value to a stop value, holding each value for a programmable dwell time.
- Sweep shapes: single, repeating sawtooth, or continuous triangle.
- Sits between the front-panel/config logic and the DDS `freq_word` input.

Parameters:
- FW_W, 8, width of frequency word and of the start/stop/step inputs.
- DWELL_W, 16, width of the dwell counter (clk cycles per frequency point).

Ports:
- clk  in  1  system clock, 10 MHz.
- rst_n  in  1  reset, asynchronous, active-high (despite the name).
- start  in  1  single-cycle pulse; begins a sweep when idle.
- stop  in  1  single-cycle pulse; aborts the sweep.
- f_start  in  FW_W  first frequency word.
- f_stop  in  FW_W  last frequency word.
- f_step  in  FW_W  increment per point; 0 is treated as 1.
- dwell  in  DWELL_W  cycles per point; 0 is treated as 1.
- mode  in  2  sweep mode: 00 single, 01 sawtooth repeat, 10 triangle, 11 same as 00.
- freq_word  out  FW_W  registered word to DDS.
- busy  out  1  high while a sweep is active.
- step_strobe  out  1  one-cycle pulse on every stepped change of freq_word.
- done  out  1  one-cycle pulse when a single sweep completes.

Behaviour:
- Reset (async, rst_n=1): state IDLE, freq_word=0, busy=0, step_strobe=0, done=0, direction=up, dwell counter=0.
- States: IDLE, DWELL, DONE.
- IDLE behaviour:
  - start=1 latches f_start, f_stop, f_step, dwell and mode into shadow registers.
  - Next cycle: freq_word=f_start, busy=1, dir=up, counter loaded with D=max(dwell,1); go to DWELL.
  - Start-to-output latency is 1 cycle.
  - Input changes after the start pulse have no effect until the next start.
- DWELL behaviour:
  - Counter decrements each cycle; each freq_word value is held exactly D cycles.
  - When counter==1, the step decision is applied on that edge. S=max(f_step,1), computed in FW_W+1 bits with no wrap.
- Up direction:
  - If freq_word<f_stop: freq_word=min(freq_word+S, f_stop). Clamping guarantees f_stop is always visited.
  - If freq_word==f_stop, the boundary action depends on mode:
    - single: go to DONE.
    - sawtooth: freq_word=f_start.
    - triangle: dir=down, freq_word=max(f_stop-S, f_start).
- Down direction (triangle only):
  - If freq_word>f_start: freq_word=max(freq_word-S, f_start).
  - If freq_word==f_start: dir=up, freq_word=min(f_start+S, f_stop).
- Step strobe and counter reload:
  - step_strobe=1 for the single cycle in which a new stepped value first appears, including sawtooth reload and triangle turn.
  - step_strobe does not fire on the initial f_start load.
  - The counter reloads with D on every step.
- Degenerate range (f_start>=f_stop): only f_start is emitted.
  - single: f_start is held D cycles, then DONE.
  - sawtooth/triangle: f_start is held until stop; no step_strobe.
- DONE: lasts one cycle; done=1, freq_word=0, busy=0; next state is IDLE. Total single-sweep duration is N·D cycles from the first f_start cycle, where N is the number of points.
- stop: from any state, next cycle gives IDLE, freq_word=0, busy=0, and no done pulse.
- Simultaneous events:
  - stop wins over start in the same cycle.
  - start while busy is ignored.
  - start in the DONE cycle is ignored.
- Reset mid-sweep forces the reset values immediately and asynchronously.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset release, then start with f_start=10, f_stop=40, f_step=10, dwell=3, mode=00:
  - freq_word = 10,10,10,20,20,20,30,30,30,40,40,40, then 0.
  - done pulses once, on the cycle after the last 40.
  - busy is high for 12 cycles.
  - step_strobe pulses 3 times.
- f_start=5, f_stop=20, f_step=7, dwell=1, mode=01:
  - freq_word sequence is 5,12,19,20,5,12,…
  - step_strobe is high every cycle after the first; done is never asserted.
- f_start=0, f_stop=8, f_step=4, dwell=2, mode=10:
  - freq_word sequence is 0,0,4,4,8,8,4,4,0,0,4,4,…
  - Assert stop mid-sequence: next cycle freq_word=0, busy=0, done=0.
- f_start=250, f_stop=255, f_step=4, dwell=1, mode=00:
  - freq_word sequence is 250,254,255, then 0 with done (no 8-bit wrap to 2).
- Edge settings:
  - f_step=0, dwell=0: steps by 1 each cycle.
  - f_start=50, f_stop=50, mode=00: 50 held for 1 cycle, then done.
  - start+stop in the same cycle: remains IDLE.
- Asynchronous reset mid-sweep between clock edges:
  - Outputs go to 0 immediately.
  - After release, a start resumes normal operation from f_start.
